// File: rtl/bask_pkg.sv
// Shared constants for the BASK transmitter: word and sample widths and the
// one-period sine table used as the carrier.
package bask_pkg;

    localparam int WIDTH     = 8;
    localparam int SAMPLE_W  = 8;
    localparam int LUT_DEPTH = 16;
    localparam int PHASE_W   = 4;

    // Offset-binary sine: 128 + round(127 * sin(2*pi*k/16))
    localparam logic [SAMPLE_W-1:0] SINE_LUT [LUT_DEPTH] = '{
        8'd128, 8'd177, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd177,
        8'd128, 8'd79,  8'd38,  8'd11,  8'd1,   8'd11,  8'd38,  8'd79
    };

endpackage

// File: rtl/bask_carrier_lut.sv
// Free-running carrier: a 4-bit phase counter addressing the sine table,
// with the table read registered so data_out trails phase by one clock.
import bask_pkg::*;

module bask_carrier_lut (
    input  logic                clk,
    input  logic                reset,
    output logic [SAMPLE_W-1:0] data_out
);

    logic [PHASE_W-1:0] phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase    <= '0;
            data_out <= '0;
        end else begin
            phase    <= phase + 1'b1;
            data_out <= SINE_LUT[phase];
        end
    end

endmodule

// File: rtl/bask_modulator.sv
// BASK/OOK transmitter: MSB-first PISO, each bit held BIT_CYCLES clocks,
// gating a continuous sine carrier onto mux_out.
import bask_pkg::*;

module bask_modulator #(
    parameter int BIT_CYCLES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    parallel_in,
    input  logic                load,
    output logic [SAMPLE_W-1:0] mux_out,
    output logic                piso_out,
    output logic [SAMPLE_W-1:0] data_out
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;

    bask_carrier_lut u_carrier (
        .clk      (clk),
        .reset    (reset),
        .data_out (data_out)
    );

    // load is a one-edge strobe with no ready/ack: it is taken on every edge
    // where it is high, overriding any shift and aborting the word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= parallel_in;
            bit_cnt   <= '0;
        end else if (bit_cnt == LAST_CNT) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt   <= '0;
        end else begin
            bit_cnt   <= bit_cnt + 1'b1;
        end
    end

    assign piso_out = shift_reg[WIDTH-1];
    assign mux_out  = piso_out ? data_out : '0;

endmodule

// File: tb/tb_bask_modulator.sv
// Bench for bask_modulator: a time-since-reset / time-since-load reference
// model pushes expected outputs each edge; they are popped and compared mid-cycle.
module tb_bask_modulator;

    localparam int BITS = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] parallel_in;
    logic       load;
    logic [7:0] mux_out;
    logic       piso_out;
    logic [7:0] data_out;

    bask_modulator #(.BIT_CYCLES(BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .parallel_in (parallel_in),
        .load        (load),
        .mux_out     (mux_out),
        .piso_out    (piso_out),
        .data_out    (data_out)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // ---------------- reference data ----------------
    int lut [16] = '{128, 177, 218, 245, 255, 245, 218, 177,
                     128, 79, 38, 11, 1, 11, 38, 79};

    logic [16:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    int          edges  = 0;     // edges since reset release
    int          k      = 0;     // edges since the last load edge
    logic        loaded = 1'b0;
    logic [7:0]  word   = 8'h00;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        logic [16:0] e_v;
        logic [7:0]  d;
        logic        p;
        int          idx;
        @(posedge clk);
        if (!reset) begin
            edges  = 0;
            loaded = 1'b0;
        end else begin
            edges++;
            if (load) begin
                loaded = 1'b1;
                k      = 0;
                word   = parallel_in;
            end else if (k < 100000) begin
                k++;
            end
        end
        d   = (edges == 0) ? 8'd0 : 8'(lut[(edges - 1) % 16]);
        idx = k / BITS;
        p   = (loaded && idx < 8) ? word[7 - idx] : 1'b0;
        exp_q.push_back({p, d, (p ? d : 8'd0)});
        @(negedge clk);
        e_v = exp_q.pop_front();
        check_val("piso_out", 32'(piso_out), 32'(e_v[16]));
        check_val("data_out", 32'(data_out), 32'(e_v[15:8]));
        check_val("mux_out",  32'(mux_out),  32'(e_v[7:0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_word(input logic [7:0] w);
        parallel_in = w;
        load        = 1'b1;
        step();
        load        = 1'b0;
        parallel_in = 8'($urandom_range(0, 255));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b0;
        load        = 1'b0;
        parallel_in = 8'h00;

        // Reset held, then free-running carrier with no word loaded
        run(3);
        reset = 1'b1;
        run(40);

        // 1000_1001 MSB first, then idle
        load_word(8'b1000_1001);
        run(8 * BITS + 30);

        // all ones, then all zeros
        load_word(8'hFF);
        run(8 * BITS + 20);
        load_word(8'h00);
        run(40);

        // Re-load mid-word, partway through bit 3
        load_word(8'hA5);
        run(3 * BITS + 10);
        load_word(8'h80);
        run(60);

        // Load coinciding with the terminal count of a running bit
        load_word(8'h7F);
        run(BITS - 1);
        load_word(8'h55);
        run(BITS + 40);

        // Asynchronous reset between edges, mid-word
        load_word(8'hFF);
        run(50);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_piso", 32'(piso_out), 32'd0);
        check_val("async_data", 32'(data_out), 32'd0);
        check_val("async_mux",  32'(mux_out),  32'd0);
        edges  = 0;
        loaded = 1'b0;
        @(negedge clk);
        run(2);
        reset = 1'b1;
        run(24);

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
